// File: rtl/resp_bus_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | resp_bus_arbiter_if : response-message types and coherence response bus    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package cache_types;
   typedef enum logic [1:0] {
      MSG_NONE = 2'd0,
      DATA     = 2'd1,
      ACK      = 2'd2,
      NACK     = 2'd3
   } mmsg_t;

   typedef struct packed {
      logic        valid;
      mmsg_t       mmsg;
      logic [31:0] addr;
      logic [3:0]  source;
      logic [1:0]  way;
      logic [31:0] data;
   } resp_msg_t;
endpackage

interface resp_bus_arbiter_if #(
   parameter int NUM_AGENTS = 4
);
   import cache_types::*;

   logic [NUM_AGENTS-1:0] resp_bus_req;
   resp_msg_t             resp_bus_tx [NUM_AGENTS];
   logic [NUM_AGENTS-1:0] resp_bus_busy;
   logic [NUM_AGENTS-1:0] resp_bus_gnt;
   resp_msg_t             resp_bus_msg;

   // Agents drive requests/messages; the arbiter answers with grant/broadcast.
   modport master (
      output resp_bus_req,
      output resp_bus_tx,
      output resp_bus_busy,
      input  resp_bus_gnt,
      input  resp_bus_msg
   );

   modport slave (
      input  resp_bus_req,
      input  resp_bus_tx,
      input  resp_bus_busy,
      output resp_bus_gnt,
      output resp_bus_msg
   );
endinterface

`default_nettype wire

// File: rtl/resp_bus_arbiter.sv
// +----------------------------------------------------------------------------+
// | resp_bus_arbiter : round-robin grant plus one-cycle broadcast register     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module resp_bus_arbiter #(
   parameter int NUM_AGENTS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   resp_bus_arbiter_if.slave    bus
);
   import cache_types::*;

   localparam int PTR_W = $clog2(NUM_AGENTS);
   localparam logic [PTR_W:0]   c_num_agents = (PTR_W+1)'(NUM_AGENTS);
   localparam logic [PTR_W-1:0] c_last_agent = PTR_W'(NUM_AGENTS - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BCAST = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [PTR_W-1:0]      r_rr_ptr;
   logic [PTR_W-1:0]      w_rr_ptr_nxt;
   resp_msg_t             r_msg_reg;
   resp_msg_t             w_msg_nxt;
   logic [NUM_AGENTS-1:0] w_gnt;
   logic                  w_found;
   logic [PTR_W-1:0]      w_winner;
   logic [PTR_W:0]        w_sum;
   logic                  w_any_busy;

   assign w_any_busy = |bus.resp_bus_busy;

   // Scan agents starting at the round-robin pointer; the first requester wins.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_sum    = '0;
      for (int i = 0; i < NUM_AGENTS; i++) begin
         w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(i);
         if (w_sum >= c_num_agents) begin
            w_sum = w_sum - c_num_agents;
         end
         if (!w_found && bus.resp_bus_req[w_sum[PTR_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_sum[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_rr_ptr_nxt    = r_rr_ptr;
      w_gnt           = '0;
      w_msg_nxt       = r_msg_reg;
      w_msg_nxt.valid = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_found && !w_any_busy) begin
               w_gnt[w_winner] = 1'b1;
               w_msg_nxt       = bus.resp_bus_tx[w_winner];
               w_msg_nxt.valid = 1'b1;
               w_rr_ptr_nxt    = (w_winner == c_last_agent) ? '0 : w_winner + 1'b1;
               w_state_nxt     = BCAST;
            end
         end
         BCAST: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_rr_ptr  <= '0;
         r_msg_reg <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_rr_ptr  <= w_rr_ptr_nxt;
         r_msg_reg <= w_msg_nxt;
      end
   end

   // Grant is combinational but must stay silent while reset is held.
   assign bus.resp_bus_gnt = rst ? '0 : w_gnt;
   assign bus.resp_bus_msg = r_msg_reg;

endmodule

`default_nettype wire

// File: tb/tb_resp_bus_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_resp_bus_arbiter : directed self-checking bench for resp_bus_arbiter    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_resp_bus_arbiter;
   import cache_types::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   resp_bus_arbiter_if #(.NUM_AGENTS(4)) bus ();

   resp_bus_arbiter #(.NUM_AGENTS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change just after the rising edge; outputs are read on the falling edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic load_tx();
      for (int a = 0; a < 4; a++) begin
         bus.resp_bus_tx[a].valid  = 1'b1;
         bus.resp_bus_tx[a].mmsg   = ACK;
         bus.resp_bus_tx[a].addr   = 32'h0000_2000 + 32'(a * 16);
         bus.resp_bus_tx[a].source = 4'(a);
         bus.resp_bus_tx[a].way    = 2'(a);
         bus.resp_bus_tx[a].data   = 32'hD000_0000 + 32'(a);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.resp_bus_req  = 4'b1111;
      bus.resp_bus_busy = 4'b0000;
      step();
      @(negedge clk);
      total++;
      if (bus.resp_bus_gnt !== 4'b0000) begin
         bad++; $display("FAIL reset_gnt: got %b want %b", bus.resp_bus_gnt, 4'b0000);
      end
      total++;
      if (bus.resp_bus_msg.valid !== 1'b0) begin
         bad++; $display("FAIL reset_valid: got %b want 0", bus.resp_bus_msg.valid);
      end
      total++;
      if (dut.r_rr_ptr !== 2'd0) begin
         bad++; $display("FAIL reset_ptr: got %0d want 0", dut.r_rr_ptr);
      end
      bus.resp_bus_req = 4'b0000;
      step();
      rst = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      bus.resp_bus_tx[2].addr = 32'h0000_1040;
      bus.resp_bus_tx[2].mmsg = DATA;
      bus.resp_bus_req = 4'b0100;
      @(negedge clk);
      total++;
      if (bus.resp_bus_gnt !== 4'b0100) begin
         bad++; $display("FAIL single_gnt: got %b want %b", bus.resp_bus_gnt, 4'b0100);
      end
      step();
      bus.resp_bus_req = 4'b0000;
      @(negedge clk);
      total++;
      if (bus.resp_bus_msg.valid !== 1'b1 || bus.resp_bus_msg.addr !== 32'h0000_1040
          || bus.resp_bus_msg.mmsg !== DATA || bus.resp_bus_msg.source !== 4'd2) begin
         bad++; $display("FAIL single_msg: got v=%b addr=%h mmsg=%0d src=%0d want v=1 addr=00001040 mmsg=1 src=2",
                         bus.resp_bus_msg.valid, bus.resp_bus_msg.addr, bus.resp_bus_msg.mmsg, bus.resp_bus_msg.source);
      end
      total++;
      if (bus.resp_bus_gnt !== 4'b0000) begin
         bad++; $display("FAIL single_bcast_gnt: got %b want 0000", bus.resp_bus_gnt);
      end
      step();
      @(negedge clk);
      total++;
      if (bus.resp_bus_msg.valid !== 1'b0) begin
         bad++; $display("FAIL single_valid_drop: got %b want 0", bus.resp_bus_msg.valid);
      end
      total++;
      if (dut.r_rr_ptr !== 2'd3) begin
         bad++; $display("FAIL single_ptr: got %0d want 3", dut.r_rr_ptr);
      end
      load_tx();
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_gnt [9];
      exp_gnt = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                  4'b0000, 4'b1000, 4'b0000, 4'b0001};
      rst = 1'b1;
      bus.resp_bus_req = 4'b1111;
      step();
      rst = 1'b0;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         total++;
         if (bus.resp_bus_gnt !== exp_gnt[c]) begin
            bad++; $display("FAIL rr_gnt cycle %0d: got %b want %b", c, bus.resp_bus_gnt, exp_gnt[c]);
         end
         step();
      end
      @(negedge clk);
      total++;
      if (bus.resp_bus_msg.valid !== 1'b1 || bus.resp_bus_msg.source !== 4'd0) begin
         bad++; $display("FAIL rr_last_msg: got v=%b src=%0d want v=1 src=0",
                         bus.resp_bus_msg.valid, bus.resp_bus_msg.source);
      end
      total++;
      if (dut.r_rr_ptr !== 2'd1) begin
         bad++; $display("FAIL rr_ptr: got %0d want 1", dut.r_rr_ptr);
      end
      bus.resp_bus_req = 4'b0000;
      step();
   endtask

   task automatic test_busy();
      do_reset();
      bus.resp_bus_req  = 4'b0010;
      bus.resp_bus_busy = 4'b1000;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total++;
         if (bus.resp_bus_gnt !== 4'b0000 || bus.resp_bus_msg.valid !== 1'b0) begin
            bad++; $display("FAIL busy_hold cycle %0d: got gnt=%b v=%b want gnt=0000 v=0",
                            c, bus.resp_bus_gnt, bus.resp_bus_msg.valid);
         end
         step();
      end
      bus.resp_bus_busy = 4'b0000;
      @(negedge clk);
      total++;
      if (bus.resp_bus_gnt !== 4'b0010) begin
         bad++; $display("FAIL busy_release_gnt: got %b want 0010", bus.resp_bus_gnt);
      end
      step();
      bus.resp_bus_req = 4'b0000;
      @(negedge clk);
      total++;
      if (bus.resp_bus_msg.valid !== 1'b1 || bus.resp_bus_msg.addr !== 32'h0000_2010) begin
         bad++; $display("FAIL busy_msg: got v=%b addr=%h want v=1 addr=00002010",
                         bus.resp_bus_msg.valid, bus.resp_bus_msg.addr);
      end
      step();
   endtask

   task automatic test_wrap();
      do_reset();
      bus.resp_bus_req = 4'b0100;
      step();
      bus.resp_bus_req = 4'b0000;
      step();
      bus.resp_bus_req = 4'b1001;
      @(negedge clk);
      total++;
      if (bus.resp_bus_gnt !== 4'b1000) begin
         bad++; $display("FAIL wrap_first: got %b want 1000", bus.resp_bus_gnt);
      end
      step();
      bus.resp_bus_req = 4'b0001;
      @(negedge clk);
      total++;
      if (bus.resp_bus_gnt !== 4'b0000 || bus.resp_bus_msg.source !== 4'd3) begin
         bad++; $display("FAIL wrap_bcast: got gnt=%b src=%0d want gnt=0000 src=3",
                         bus.resp_bus_gnt, bus.resp_bus_msg.source);
      end
      step();
      @(negedge clk);
      total++;
      if (bus.resp_bus_gnt !== 4'b0001) begin
         bad++; $display("FAIL wrap_second: got %b want 0001", bus.resp_bus_gnt);
      end
      step();
      bus.resp_bus_req = 4'b0000;
      @(negedge clk);
      total++;
      if (dut.r_rr_ptr !== 2'd1) begin
         bad++; $display("FAIL wrap_ptr: got %0d want 1", dut.r_rr_ptr);
      end
      step();
   endtask

   task automatic test_valid_ignored();
      do_reset();
      bus.resp_bus_tx[0].valid = 1'b0;
      bus.resp_bus_tx[0].mmsg  = NACK;
      bus.resp_bus_tx[0].addr  = 32'hA5A5_0000;
      bus.resp_bus_tx[0].way   = 2'd3;
      bus.resp_bus_tx[0].data  = 32'h1234_5678;
      bus.resp_bus_req = 4'b0001;
      step();
      bus.resp_bus_req = 4'b0000;
      @(negedge clk);
      total++;
      if (bus.resp_bus_msg.valid !== 1'b1 || bus.resp_bus_msg.mmsg !== NACK
          || bus.resp_bus_msg.addr !== 32'hA5A5_0000 || bus.resp_bus_msg.way !== 2'd3
          || bus.resp_bus_msg.data !== 32'h1234_5678) begin
         bad++; $display("FAIL txvalid_ignored: got v=%b mmsg=%0d addr=%h way=%0d data=%h want v=1 mmsg=3 addr=a5a50000 way=3 data=12345678",
                         bus.resp_bus_msg.valid, bus.resp_bus_msg.mmsg, bus.resp_bus_msg.addr,
                         bus.resp_bus_msg.way, bus.resp_bus_msg.data);
      end
      step();
      load_tx();
   endtask

   task automatic test_reset_in_bcast();
      do_reset();
      bus.resp_bus_req = 4'b0010;
      @(negedge clk);
      total++;
      if (bus.resp_bus_gnt !== 4'b0010) begin
         bad++; $display("FAIL rstb_grant: got %b want 0010", bus.resp_bus_gnt);
      end
      step();
      rst = 1'b1;
      step();
      @(negedge clk);
      total++;
      if (bus.resp_bus_msg.valid !== 1'b0 || bus.resp_bus_gnt !== 4'b0000 || dut.r_rr_ptr !== 2'd0) begin
         bad++; $display("FAIL rstb_after: got v=%b gnt=%b ptr=%0d want v=0 gnt=0000 ptr=0",
                         bus.resp_bus_msg.valid, bus.resp_bus_gnt, dut.r_rr_ptr);
      end
      step();
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (bus.resp_bus_gnt !== 4'b0010) begin
         bad++; $display("FAIL rstb_regrant: got %b want 0010", bus.resp_bus_gnt);
      end
      step();
      bus.resp_bus_req = 4'b0000;
      step();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.resp_bus_req  = '0;
      bus.resp_bus_busy = '0;
      load_tx();
      #1;
      test_reset();
      test_single();
      test_round_robin();
      test_busy();
      test_wrap();
      test_valid_ignored();
      test_reset_in_bcast();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/resp_bus_arbiter.md
# resp_bus_arbiter

Round-robin arbiter and broadcast register for the coherence response bus. It collects response-bus requests from every agent, grants one agent at a time, and broadcasts the winner's message to all agents for exactly one cycle. Agents include the per-core L1s, the L2 coherence controller and the memory-side responder. It sits directly downstream of the L2 coherence controller's `resp_bus_req` / `resp_bus_tx` / `resp_bus_busy` outputs and feeds back `resp_bus_gnt` and `resp_bus_msg`.

## Interface
- `NUM_AGENTS`, 4: number of response-bus agents; legal range 2..16.
- `PTR_W`, `$clog2(NUM_AGENTS)`: round-robin pointer width (derived, not overridden).

Ports (`resp_msg_t` from `cache_types`):
- `clk`  in  1  clock. Single clock domain; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `resp_bus_req`  in  NUM_AGENTS  per-agent request, level-held until the agent sees its own message broadcast.
- `resp_bus_tx`  in  resp_msg_t [NUM_AGENTS]  per-agent candidate message, sampled at grant.
- `resp_bus_busy`  in  NUM_AGENTS  per-agent stall; any bit high blocks new grants.
- `resp_bus_gnt`  out  NUM_AGENTS  one-hot grant, combinational, at most one bit high.
- `resp_bus_msg`  out  resp_msg_t  registered broadcast message; `valid` high one cycle per grant.

## Operation
- FSM states:
  - `IDLE`: grant allowed.
  - `BCAST`: broadcasting; no grant.
- Registers:
  - `state`.
  - `rr_ptr` (`PTR_W` bits).
  - `msg_reg` (`resp_msg_t`).
- In `IDLE`, when `|resp_bus_req && !(|resp_bus_busy)`:
  - Winner = first requesting agent scanning `rr_ptr`, `rr_ptr+1`, … modulo `NUM_AGENTS`.
  - Assert `resp_bus_gnt[winner]` this cycle.
  - At the clock edge: `msg_reg <= resp_bus_tx[winner]` with `valid` forced to 1.
  - At the clock edge: `rr_ptr <= (winner+1) mod NUM_AGENTS`; wrap from `NUM_AGENTS-1` to 0.
  - At the clock edge: `state <= BCAST`.
- In `IDLE` with no request or any busy bit high:
  - `resp_bus_gnt = 0`.
  - `msg_reg.valid <= 0`.
  - `rr_ptr` unchanged; stay in `IDLE`.
- In `BCAST`:
  - `resp_bus_msg = msg_reg` (`valid = 1`).
  - `resp_bus_gnt = 0`, regardless of requests or busy.
  - At the clock edge: `msg_reg.valid <= 0`, `state <= IDLE`.
- `resp_bus_msg` is always driven directly from `msg_reg`.
- Other `msg_reg` fields hold their last value when `valid = 0`; consumers must qualify on `valid`.
- The `valid` field of `resp_bus_tx[winner]` is ignored; the grant alone makes a broadcast valid.
- A request dropped before it is granted is abandoned silently; no state is kept per agent.
- `resp_bus_busy` gates the grant decision only. It does not extend or cancel a broadcast already in `BCAST`.

## Timing
- Reset values:
  - `state = IDLE`, `rr_ptr = 0`.
  - `msg_reg = '0`, so `resp_bus_msg.valid = 0`.
  - `resp_bus_gnt = 0` in every cycle `rst` is high.
- Grant latency: `resp_bus_gnt` is high in the same cycle T that the request is seen in `IDLE` (combinational from `state`, `rr_ptr`, `resp_bus_req`, `resp_bus_busy`).
- Broadcast latency: `resp_bus_msg.valid` is high in cycle T+1 only, carrying the data captured in T.
- Requester handshake: the agent deasserts `resp_bus_req` combinationally in T+1 on seeing its own source/way. The arbiter sees the deassert no later than T+2, which is the next `IDLE` cycle.
- Peak throughput is one broadcast every 2 cycles. Back-to-back requesters are granted at T, T+2, T+4, …
- With all agents requesting continuously, each agent is granted at least once every `2*NUM_AGENTS` cycles while busy is low.
- Busy and request rise in the same cycle: no grant that cycle; grant occurs the first cycle busy is low.
- Reset in `BCAST`: the next cycle is `IDLE` with `valid = 0`; the broadcast in progress is lost.
- Reset in an `IDLE` grant cycle: the grant is still visible combinationally unless `rst` is high. `resp_bus_gnt` is forced to 0 while `rst = 1`.

## Test plan
- Reset, then agent 2 alone requests with `tx.addr = 32'h0000_1040`, `mmsg = DATA`:
  - `gnt = 4'b0100` in cycle T.
  - `resp_bus_msg.valid = 1`, `addr = 32'h1040`, `mmsg = DATA` in T+1.
  - `valid = 0` in T+2.
  - `rr_ptr = 3`.
- All four agents hold requests continuously from reset:
  - Grants are `0001, 0010, 0100, 1000, 0001` at cycles T, T+2, T+4, T+6, T+8.
  - `gnt = 0` on every odd cycle.
- Agent 1 requests while `resp_bus_busy = 4'b1000` for 5 cycles:
  - No grant and `valid = 0` for those 5 cycles.
  - `gnt = 4'b0010` the first cycle busy drops.
- Wrap-around: `rr_ptr = 3`, agents 0 and 3 request:
  - Agent 3 is granted first.
  - Agent 0 is granted 2 cycles later.
  - `rr_ptr` ends at 1.
- Agent 0 presents `tx.valid = 0` at grant: broadcast `resp_bus_msg.valid = 1` with the other fields copied unchanged.
- Reset asserted in a `BCAST` cycle:
  - The following cycle has `valid = 0`, `gnt = 0`, `rr_ptr = 0`.
  - A held request from agent 1 is granted in the first cycle after `rst` deasserts.
